// File: rtl/seven_segment_capture_if.sv
// Bus between a multiplexed seven-segment driver and seven_segment_capture.
// The master drives the segment/anode lines; the slave returns the recovered digits.
interface seven_segment_capture_if;
    logic [6:0] seg_data;
    logic [3:0] AN_value;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] digit_valid;
    logic       digit_strobe;
    logic       frame_valid;
    logic       err;

    modport master (
        output seg_data, AN_value,
        input  a, b, c, d, digit_valid, digit_strobe, frame_valid, err
    );

    modport slave (
        input  seg_data, AN_value,
        output a, b, c, d, digit_valid, digit_strobe, frame_valid, err
    );
endinterface

// File: rtl/seven_segment_capture.sv
// Recovers four BCD digits from a multiplexed, active-low seven-segment display bus.
// Optional macro SEGCAP_ERR_EN enables the sticky decode/anode error flag on err.
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input logic                    clk,
    input logic                    reset,
    seven_segment_capture_if.slave bus
);

    typedef enum logic [0:0] {StCollect, StDone} state_e;

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

    // Two-deep sample pipe: s1 is the current sample, s2 the one before it.
    logic [3:0] an_s1_q, an_s2_q;
    logic [6:0] seg_s1_q, seg_s2_q;
    logic [7:0] cnt_q;
    logic       fired_q;
    state_e     state_q;
    logic [3:0] a_q, b_q, c_q, d_q;
    logic [3:0] valid_q;
    logic       strobe_q;
    logic       frame_q;

    logic       same;
    logic       window_hit;
    logic [3:0] sel;
    logic       an_onehot;
    logic       capture;
    logic [3:0] dec_val;

    assign same       = (an_s1_q == an_s2_q) && (seg_s1_q == seg_s2_q);
    // Counter at max means s2 is the last of a full stable run; fire once per run.
    assign window_hit = (cnt_q == StableMax) && !fired_q;
    assign sel        = ~an_s2_q;
    assign an_onehot  = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign capture    = window_hit && an_onehot;

    always_comb begin
        dec_val = 4'hE;
        case (seg_s2_q)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default:    dec_val = 4'hE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an_s1_q  <= 4'b1111;
            an_s2_q  <= 4'b1111;
            seg_s1_q <= 7'b1111111;
            seg_s2_q <= 7'b1111111;
            cnt_q    <= 8'd0;
            fired_q  <= 1'b0;
            state_q  <= StCollect;
            a_q      <= 4'hF;
            b_q      <= 4'hF;
            c_q      <= 4'hF;
            d_q      <= 4'hF;
            valid_q  <= 4'b0000;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            an_s1_q  <= bus.AN_value;
            seg_s1_q <= bus.seg_data;
            an_s2_q  <= an_s1_q;
            seg_s2_q <= seg_s1_q;

            if (!same) begin
                cnt_q   <= 8'd1;
                fired_q <= 1'b0;
            end else if (cnt_q != StableMax) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                fired_q <= 1'b1;
            end

            strobe_q <= capture;
            if (capture) begin
                unique case (sel)
                    4'b1000: a_q <= dec_val;
                    4'b0100: b_q <= dec_val;
                    4'b0010: c_q <= dec_val;
                    4'b0001: d_q <= dec_val;
                endcase
            end

            unique case (state_q)
                StCollect: begin
                    frame_q <= 1'b0;
                    if (capture) begin
                        valid_q <= valid_q | sel;
                        if ((valid_q | sel) == 4'b1111) begin
                            state_q <= StDone;
                            frame_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // A capture landing on the clear cycle survives the clear.
                    frame_q <= 1'b0;
                    state_q <= StCollect;
                    valid_q <= capture ? sel : 4'b0000;
                end
            endcase
        end
    end

`ifdef SEGCAP_ERR_EN
    logic an_idle;
    logic err_q;

    assign an_idle = (an_s2_q == 4'b1111);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (window_hit && ((an_onehot && dec_val == 4'hE) || (!an_onehot && !an_idle))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.a            = a_q;
    assign bus.b            = b_q;
    assign bus.c            = c_q;
    assign bus.d            = d_q;
    assign bus.digit_valid  = valid_q;
    assign bus.digit_strobe = strobe_q;
    assign bus.frame_valid  = frame_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scenarios plus randomized segment/anode runs,
// all checked every cycle against a run-length reference model.
module tb_seven_segment_capture;

    localparam int unsigned N = 16;

`ifdef SEGCAP_ERR_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    seven_segment_capture_if bus ();

    seven_segment_capture #(.STABLE_CYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        int         due;
        logic [3:0] an;
        logic [6:0] seg;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         run;
    logic [3:0] prev_an;
    logic [6:0] prev_seg;
    logic [3:0] m_dig[4];  // index 0 = d ... 3 = a
    logic [3:0] m_valid;
    logic       m_strobe;
    logic       m_frame;
    logic       m_err;

    int strobes;
    int frames;
    int last_strobe_cyc;

    logic [6:0] seg_tab[11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                                7'b1111111};
    logic [3:0] an_tab[7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0000, 4'b1100};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] seg2dig(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (s == seg_tab[i]) return 4'(i);
        end
        if (s == 7'b1111111) return 4'hF;
        return 4'hE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
        m_valid  = 4'b0000;
        m_strobe = 1'b0;
        m_frame  = 1'b0;
        m_err    = 1'b0;
        prev_an  = 4'b1111;
        prev_seg = 7'b1111111;
        run      = 1;
        evq.delete();
    endtask

    // One clock edge: advance the model with the inputs seen at that edge, then compare.
    task automatic step();
        ev_t  ev;
        logic hit;
        logic was_done;
        int   idx;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            model_reset();
        end else begin
            hit = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                ev  = evq.pop_front();
                hit = 1'b1;
            end
            if (bus.AN_value == prev_an && bus.seg_data == prev_seg) run++;
            else run = 1;
            prev_an  = bus.AN_value;
            prev_seg = bus.seg_data;
            // A run of N identical samples shows up two edges after its N-th sample.
            if (run == N) evq.push_back('{cyc + 2, bus.AN_value, bus.seg_data});

            was_done = m_frame;
            m_frame  = 1'b0;
            m_strobe = 1'b0;
            if (was_done) m_valid = 4'b0000;
            if (hit && ev.an != 4'b1111) begin
                if (ev.an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}) begin
                    idx = (ev.an == 4'b1110) ? 0 : (ev.an == 4'b1101) ? 1 :
                          (ev.an == 4'b1011) ? 2 : 3;
                    m_dig[idx]   = seg2dig(ev.seg);
                    m_strobe     = 1'b1;
                    m_valid[idx] = 1'b1;
                    if (m_dig[idx] == 4'hE) m_err = ErrExp;
                    if (!was_done && m_valid == 4'b1111) m_frame = 1'b1;
                end else begin
                    m_err = ErrExp;
                end
            end
        end
        #1;
        check_val("a", bus.a, m_dig[3]);
        check_val("b", bus.b, m_dig[2]);
        check_val("c", bus.c, m_dig[1]);
        check_val("d", bus.d, m_dig[0]);
        check_val("digit_valid", bus.digit_valid, m_valid);
        check_val("digit_strobe", bus.digit_strobe, m_strobe);
        check_val("frame_valid", bus.frame_valid, m_frame);
        check_val("err", bus.err, m_err);
        if (bus.digit_strobe === 1'b1) begin
            strobes++;
            last_strobe_cyc = cyc;
        end
        if (bus.frame_valid === 1'b1) frames++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.AN_value = an;
        bus.seg_data = seg;
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_a"}, bus.a, 4'hF);
        check_val({tag, "_b"}, bus.b, 4'hF);
        check_val({tag, "_c"}, bus.c, 4'hF);
        check_val({tag, "_d"}, bus.d, 4'hF);
        check_val({tag, "_valid"}, bus.digit_valid, 4'b0000);
        check_val({tag, "_strobe"}, bus.digit_strobe, 1'b0);
        check_val({tag, "_frame"}, bus.frame_valid, 1'b0);
        check_val({tag, "_err"}, bus.err, 1'b0);
    endtask

    initial begin
        int start;
        logic [3:0] an;
        logic [6:0] seg;

        reset        = 1'b0;
        bus.AN_value = 4'b1111;
        bus.seg_data = 7'b1111111;
        do_reset(3);
        check_reset_state("rst");

        // Single stable digit: one strobe, 17 edges after the first sample.
        strobes = 0;
        start   = cyc + 1;
        hold(4'b1110, 7'b0100100, 20);
        check_val("one_d", bus.d, 4'd5);
        check_val("one_valid", bus.digit_valid, 4'b0001);
        check_val("one_strobes", strobes, 1);
        check_val("one_latency", last_strobe_cyc - start, N + 1);

        // Full frame a..d = 1,2,3,4.
        do_reset(2);
        frames = 0;
        hold(4'b0111, 7'b1001111, 32);
        hold(4'b1011, 7'b0010010, 32);
        hold(4'b1101, 7'b0000110, 32);
        hold(4'b1110, 7'b1001100, 32);
        check_val("frm_a", bus.a, 4'd1);
        check_val("frm_b", bus.b, 4'd2);
        check_val("frm_c", bus.c, 4'd3);
        check_val("frm_d", bus.d, 4'd4);
        check_val("frm_count", frames, 1);
        check_val("frm_valid", bus.digit_valid, 4'b0000);

        // Unstable segments never capture.
        do_reset(2);
        strobes = 0;
        repeat (6) begin
            hold(4'b1101, 7'b0000110, 10);
            hold(4'b1101, 7'b1001111, 10);
        end
        check_val("tog_c", bus.c, 4'hF);
        check_val("tog_strobes", strobes, 0);

        // Bad segment pattern and multi-low anode.
        do_reset(2);
        hold(4'b1011, 7'b1111110, 20);
        check_val("dec_b", bus.b, 4'hE);
        check_val("dec_err", bus.err, ErrExp);
        strobes = 0;
        hold(4'b0000, 7'b0000001, 20);
        check_val("an_strobes", strobes, 0);
        check_val("an_err", bus.err, ErrExp);

        // Reset mid-frame discards progress.
        do_reset(2);
        hold(4'b0111, 7'b0000000, 32);
        hold(4'b1011, 7'b0001111, 32);
        hold(4'b1101, 7'b0100000, 32);
        check_val("mid_valid", bus.digit_valid, 4'b1110);
        do_reset(2);
        check_reset_state("mid_rst");
        frames = 0;
        hold(4'b0111, 7'b0000100, 32);
        hold(4'b1011, 7'b0000001, 32);
        hold(4'b1101, 7'b0010010, 32);
        check_val("mid_frames3", frames, 0);
        hold(4'b1110, 7'b0000110, 32);
        check_val("mid_frames4", frames, 1);

        // Randomized runs.
        repeat (150) begin
            if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
            an  = (($urandom_range(0, 7) == 7) ? 4'($urandom) : an_tab[$urandom_range(0, 6)]);
            seg = (($urandom_range(0, 9) < 7) ? seg_tab[$urandom_range(0, 10)] : 7'($urandom));
            hold(an, seg, $urandom_range(1, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

endmodule
